fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 73 +++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: single-cycle instruction fetch with IF/ID register, branch/jump redirect and squash bubble
// Ports: clk/reset_n (sync active-low); stall holds everything; branch_valid/branch/branch_target and
// jump/jump_target request a redirect from decode; imem_addr/imem_rdata talk to an async-read memory;
// ifid_instr/ifid_pc/ifid_pc4/ifid_valid form the IF/ID register; flush marks a squashed bubble,
// misalign pulses for a target with nonzero low bits, squash_cnt saturates at 16'hFFFF.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        flush,
  output logic        misalign,
  output logic [15:0] squash_cnt
);
  localparam logic [0:0] FETCH  = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;
  logic [0:0]  state;
  logic [31:0] pc, pc4, target;
  logic        redirect;
  assign imem_addr = pc;
  always_comb begin
    pc4      = pc + 32'd4;
    target   = jump ? jump_target : branch_target;
    // a bubble in decode (squash or post-reset) carries no branch/jump to act on
    redirect = !stall && ifid_valid && state == FETCH && (jump || (branch_valid && branch));
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= 32'd0;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
      flush      <= 1'b0;
      misalign   <= 1'b0;
      squash_cnt <= 16'd0;
      state      <= FETCH;
    end else if (stall) begin
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else if (redirect) begin
      pc         <= {target[31:2], 2'b00};
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      flush      <= 1'b1;
      misalign   <= |target[1:0];
      squash_cnt <= squash_cnt + {15'd0, squash_cnt != 16'hFFFF};
      state      <= SQUASH;
    end else begin
      pc         <= pc4;
      ifid_instr <= imem_rdata;
      ifid_pc    <= pc;
      ifid_pc4   <= pc4;
      ifid_valid <= 1'b1;
      flush      <= 1'b0;
      misalign   <= 1'b0;
      state      <= FETCH;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural pipeline model
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset_n, stall, branch_valid, branch, jump;
  logic [31:0] branch_target, jump_target, imem_addr, imem_rdata;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
  logic        ifid_valid, flush, misalign;
  logic [15:0] squash_cnt;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;
  logic        w_valid, w_flush, w_mis;
  logic [15:0] w_cnt;
  int          checks = 0, errors = 0;
  logic        chk = 1'b0;
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
  logic        m_valid, m_flush, m_mis;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'd0 ? 32'h1111_1111 : a == 32'd4 ? 32'h2222_2222 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  assign imem_rdata = mem(imem_addr);
  assign w_rdata    = mem(w_addr);

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_valid(branch_valid), .branch(branch),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .flush(flush), .misalign(misalign), .squash_cnt(squash_cnt)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset_n(reset_n), .stall(1'b0), .branch_valid(1'b0), .branch(1'b0),
    .branch_target(32'd0), .jump(1'b0), .jump_target(32'd0), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .ifid_instr(w_instr), .ifid_pc(w_pc), .ifid_pc4(w_pc4),
    .ifid_valid(w_valid), .flush(w_flush), .misalign(w_mis), .squash_cnt(w_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: one step of the pipeline per edge, straight from the fetch/redirect rules
  always @(posedge clk) begin
    if (!reset_n) begin
      m_pc <= 32'd0; m_instr <= 32'd0; m_ipc <= 32'd0; m_ipc4 <= 32'd0;
      m_valid <= 1'b0; m_flush <= 1'b0; m_mis <= 1'b0; m_cnt <= 16'd0;
    end else if (stall) begin
      m_flush <= 1'b0; m_mis <= 1'b0;
    end else if (m_valid && (jump || (branch_valid && branch))) begin
      m_pc    <= (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
      m_mis   <= (jump ? jump_target[1:0] : branch_target[1:0]) != 2'b00;
      m_instr <= 32'd0;
      m_valid <= 1'b0;
      m_flush <= 1'b1;
      m_cnt   <= m_cnt == 16'hFFFF ? m_cnt : m_cnt + 16'd1;
    end else begin
      m_instr <= mem(m_pc);
      m_ipc   <= m_pc;
      m_ipc4  <= m_pc + 32'd4;
      m_pc    <= m_pc + 32'd4;
      m_valid <= 1'b1; m_flush <= 1'b0; m_mis <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk) begin
      check("imem_addr", imem_addr, m_pc);
      check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      check("ifid_instr", ifid_instr, m_instr);
      check("flush", {31'd0, flush}, {31'd0, m_flush});
      check("misalign", {31'd0, misalign}, {31'd0, m_mis});
      check("squash_cnt", {16'd0, squash_cnt}, {16'd0, m_cnt});
      if (m_valid) begin
        check("ifid_pc", ifid_pc, m_ipc);
        check("ifid_pc4", ifid_pc4, m_ipc4);
      end
    end
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch_valid = 1'b0; branch = 1'b0; jump = 1'b0;
    branch_target = 32'd0; jump_target = 32'd0;
    @(posedge clk); #1;
    chk = 1'b1;
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_cnt", {16'd0, squash_cnt}, 32'd0);
    check("rst_instr", ifid_instr, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("first_instr", ifid_instr, 32'h1111_1111);
    check("first_pc", ifid_pc, 32'd0);
    check("first_valid", {31'd0, ifid_valid}, 32'd1);
    check("wrap_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", w_pc4, 32'd0);
    @(posedge clk); #1;
    check("second_instr", ifid_instr, 32'h2222_2222);
    check("second_pc", ifid_pc, 32'd4);
    check("wrap_next_pc", w_pc, 32'd0);
    @(posedge clk); #1;
    check("pc8", ifid_pc, 32'd8);
    @(negedge clk); branch_valid = 1'b1; branch = 1'b1; branch_target = 32'h40;
    @(posedge clk); #1;
    check("br_valid", {31'd0, ifid_valid}, 32'd0);
    check("br_flush", {31'd0, flush}, 32'd1);
    check("br_cnt", {16'd0, squash_cnt}, 32'd1);
    @(negedge clk); branch_valid = 1'b0; branch = 1'b0;
    @(posedge clk); #1;
    check("br_target_pc", ifid_pc, 32'h40);
    @(negedge clk); stall = 1'b1; jump = 1'b1; jump_target = 32'h80;
    repeat (2) begin
      @(posedge clk); #1;
      check("stall_ifid_pc", ifid_pc, 32'h40);
      check("stall_addr", imem_addr, 32'h44);
    end
    @(negedge clk); stall = 1'b0;
    @(posedge clk); #1;
    check("jmp_addr", imem_addr, 32'h80);
    check("jmp_flush", {31'd0, flush}, 32'd1);
    @(negedge clk); jump = 1'b0;
    @(posedge clk); #1;
    check("jmp_ifid_pc", ifid_pc, 32'h80);
    @(negedge clk); jump = 1'b1; jump_target = 32'h100; branch_valid = 1'b1; branch = 1'b1; branch_target = 32'h200;
    @(posedge clk); #1;
    check("prio_addr", imem_addr, 32'h100);
    @(negedge clk); jump = 1'b0; branch_valid = 1'b0; branch = 1'b0;
    @(posedge clk); #1;
    check("prio_ifid_pc", ifid_pc, 32'h100);
    @(negedge clk); branch_valid = 1'b1; branch = 1'b1; branch_target = 32'h43;
    @(posedge clk); #1;
    check("mis_addr", imem_addr, 32'h40);
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    @(negedge clk); branch_valid = 1'b0; branch = 1'b0;
    @(posedge clk); #1;
    check("mis_clear", {31'd0, misalign}, 32'd0);
    check("mis_ifid_pc", ifid_pc, 32'h40);
    @(negedge clk); jump = 1'b1; jump_target = 32'h44;
    @(posedge clk); #1;
    check("self_flush", {31'd0, flush}, 32'd1);
    check("self_cnt", {16'd0, squash_cnt}, 32'd5);
    @(negedge clk); jump = 1'b0;
    @(posedge clk); #1;
    check("self_ifid_pc", ifid_pc, 32'h44);
    @(negedge clk); jump = 1'b1; jump_target = 32'h200;
    @(posedge clk); #1;
    check("sq_flush", {31'd0, flush}, 32'd1);
    @(negedge clk); jump = 1'b0; reset_n = 1'b0; stall = 1'b1;
    @(posedge clk); #1;
    check("sqrst_addr", imem_addr, 32'd0);
    check("sqrst_valid", {31'd0, ifid_valid}, 32'd0);
    check("sqrst_flush", {31'd0, flush}, 32'd0);
    check("sqrst_cnt", {16'd0, squash_cnt}, 32'd0);
    @(negedge clk); reset_n = 1'b1; stall = 1'b0;
    force dut.squash_cnt = 16'hFFFE;
    m_cnt <= 16'hFFFE;
    #1 release dut.squash_cnt;
    jump = 1'b1; jump_target = 32'h10;
    repeat (6) @(posedge clk);
    #1;
    check("sat_cnt", {16'd0, squash_cnt}, 32'h0000_FFFF);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset_n       = ($urandom % 100) != 0;
      stall         = ($urandom % 4) == 0;
      jump          = ($urandom % 5) == 0;
      branch_valid  = ($urandom % 3) == 0;
      branch        = $urandom % 2;
      jump_target   = ($urandom % 8) == 0 ? 32'hFFFF_FFF8 | ($urandom % 4) : $urandom;
      branch_target = $urandom;
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
